// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
// Posted-write buffer sitting between the CPU data-memory port and a slower
// handshaked data memory. Stores retire into a small FIFO and drain in the
// background; loads hitting a buffered address are forwarded from the FIFO,
// loads that miss wait for the FIFO to empty and then read memory.
module dmem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_write,
    input  logic              cpu_read,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        RD_REQ,
        RD_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   ldAddr_q, ldAddr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [ADDR_W-1:0]   addrMem_q [DEPTH];
    logic [DATA_W-1:0]   dataMem_q [DEPTH];

    logic                push;
    logic                pop;
    logic                full;
    logic                drainActive;
    logic                fwdHit;
    logic [DATA_W-1:0]   fwdData;
    logic [PTR_W-1:0]    scanIdx;

    assign full = (count_q == CNT_W'(DEPTH));

    // Memory-side outputs and the drain engine; driven only from registered state
    always_comb begin
        drainActive = ((state_q == IDLE) || (state_q == DRAIN)) && (count_q != '0);
        mem_write   = drainActive;
        mem_read    = (state_q == RD_REQ);
        mem_addr    = '0;
        mem_wdata   = '0;
        pop         = drainActive && mem_ready;
        if (drainActive) begin
            mem_addr  = addrMem_q[head_q];
            mem_wdata = dataMem_q[head_q];
        end else if (state_q == RD_REQ) begin
            mem_addr = ldAddr_q;
        end
    end

    // Forwarding search: scan oldest to newest so the newest matching entry wins
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        scanIdx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            scanIdx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addrMem_q[scanIdx] == cpu_addr)) begin
                fwdHit  = 1'b1;
                fwdData = dataMem_q[scanIdx];
            end
        end
    end

    // Control FSM: store acceptance, load forwarding/miss handling, CPU-side outputs
    always_comb begin
        state_d   = state_q;
        ldAddr_d  = ldAddr_q;
        rdata_d   = rdata_q;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    if (full) begin
                        cpu_stall = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else if (cpu_read) begin
                    if (fwdHit) begin
                        cpu_rdata = fwdData;
                    end else begin
                        cpu_stall = 1'b1;
                        ldAddr_d  = cpu_addr;
                        state_d   = (count_q != '0) ? DRAIN : RD_REQ;
                    end
                end
            end
            DRAIN: begin
                cpu_stall = 1'b1;
                if (count_q == '0) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                cpu_stall = 1'b1;
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                cpu_rdata = rdata_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
    end

    // Control state register; reset drops any outstanding request and discards buffered writes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ldAddr_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ldAddr_q <= ldAddr_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage; contents are only meaningful under count, so no reset is needed
    always_ff @(posedge clock) begin
        if (push) begin
            addrMem_q[tail_q] <= cpu_addr;
            dataMem_q[tail_q] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer
// Directed bench for dmem_write_buffer. Stimulus pushes expected memory writes,
// memory reads and load results into queues; a monitor on the falling edge
// pops and compares whenever the DUT presents the matching activity.
module tb_dmem_write_buffer;

    logic        clock;
    logic        reset;
    logic [15:0] cpuAddr;
    logic [15:0] cpuWdata;
    logic        cpuWrite;
    logic        cpuRead;
    logic [15:0] cpuRdata;
    logic        cpuStall;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic        memWrite;
    logic        memRead;
    logic [15:0] memRdata;
    logic        memReady;

    int assertCount = 0;
    int failCount   = 0;
    int writeSeen   = 0;
    int readAsserted = 0;

    logic [31:0] expWr [$];
    logic [15:0] expRd [$];
    logic [15:0] expRdAddr [$];

    dmem_write_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpuAddr),
        .cpu_wdata (cpuWdata),
        .cpu_write (cpuWrite),
        .cpu_read  (cpuRead),
        .cpu_rdata (cpuRdata),
        .cpu_stall (cpuStall),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_write (memWrite),
        .mem_read  (memRead),
        .mem_rdata (memRdata),
        .mem_ready (memReady)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr, input logic [15:0] data);
        cpuWrite = wr;
        cpuRead  = rd;
        cpuAddr  = addr;
        cpuWdata = data;
    endtask

    // Issue one store and hold it until accepted; returns the number of stalled cycles
    task automatic doStore(input logic [15:0] addr, input logic [15:0] data, output int stallCycles);
        stallCycles = 0;
        expWr.push_back({addr, data});
        applyStimulus(1'b1, 1'b0, addr, data);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!cpuStall) break;
            stallCycles++;
            if (i == 49) checkOutput("store timeout", 32'd1, 32'd0);
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Issue one load and hold it until the stall clears; returns the number of stalled cycles
    task automatic doLoad(input logic [15:0] addr, input logic [15:0] expData, input logic isMiss, output int stallCycles);
        stallCycles = 0;
        expRd.push_back(expData);
        if (isMiss) expRdAddr.push_back(addr);
        applyStimulus(1'b0, 1'b1, addr, 16'h0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!cpuStall) break;
            stallCycles++;
            if (i == 49) checkOutput("load timeout", 32'd1, 32'd0);
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Wait (bounded) until every expected memory write has been observed
    task automatic waitDrain(input string name);
        for (int i = 0; i < 100 && expWr.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        checkOutput(name, expWr.size(), 32'd0);
    endtask

    // Monitor: compares memory transactions and completed loads against the queues
    always @(negedge clock) begin
        if (!reset) begin
            if (memRead) readAsserted++;
            if (memRead || memWrite) begin
                checkOutput("read/write exclusive", {31'd0, memRead && memWrite}, 32'd0);
            end
            if (memWrite && memReady) begin
                logic [31:0] e;
                writeSeen++;
                if (expWr.size() == 0) begin
                    checkOutput("unexpected mem write", {memAddr, memWdata}, 32'hFFFF_FFFF);
                end else begin
                    e = expWr.pop_front();
                    checkOutput("mem write addr", {16'h0, memAddr}, {16'h0, e[31:16]});
                    checkOutput("mem write data", {16'h0, memWdata}, {16'h0, e[15:0]});
                end
            end
            if (memRead && memReady) begin
                checkOutput("writes drained before read", expWr.size(), 32'd0);
                if (expRdAddr.size() == 0) begin
                    checkOutput("unexpected mem read", {16'h0, memAddr}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("mem read addr", {16'h0, memAddr}, {16'h0, expRdAddr.pop_front()});
                end
            end
            if (cpuRead && !cpuWrite && !cpuStall) begin
                if (expRd.size() == 0) begin
                    checkOutput("unexpected load completion", {16'h0, cpuRdata}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("load data", {16'h0, cpuRdata}, {16'h0, expRd.pop_front()});
                end
            end
        end
    end

    // Directed test sequence
    initial begin
        int sc;
        int snap;
        reset    = 1'b1;
        memReady = 1'b0;
        memRdata = 16'h0;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("reset mem_write", {31'd0, memWrite}, 32'd0);
        checkOutput("reset mem_read",  {31'd0, memRead},  32'd0);
        checkOutput("reset mem_addr",  {16'h0, memAddr},  32'd0);
        checkOutput("reset mem_wdata", {16'h0, memWdata}, 32'd0);
        checkOutput("reset cpu_stall", {31'd0, cpuStall}, 32'd0);
        checkOutput("reset cpu_rdata", {16'h0, cpuRdata}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Store then forward from the entry being popped this cycle
        $display("[TB] store/forward 0x0010");
        memReady = 1'b1;
        snap = readAsserted;
        doStore(16'h0010, 16'hAAAA, sc);
        checkOutput("store no stall", sc, 32'd0);
        doLoad(16'h0010, 16'hAAAA, 1'b0, sc);
        checkOutput("forward no stall", sc, 32'd0);
        checkOutput("forward no mem_read", readAsserted - snap, 32'd0);
        waitDrain("drain after forward");

        // Newest duplicate wins; both writes still reach memory in order
        $display("[TB] duplicate address 0x0020");
        memReady = 1'b0;
        doStore(16'h0020, 16'h1111, sc);
        doStore(16'h0020, 16'h2222, sc);
        doLoad(16'h0020, 16'h2222, 1'b0, sc);
        checkOutput("dup forward no stall", sc, 32'd0);
        memReady = 1'b1;
        waitDrain("drain duplicates");

        // Fill the buffer; fifth store stalls until a pop frees a slot
        $display("[TB] full buffer");
        memReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            doStore(16'h0030 + 16'(i), 16'h3000 + 16'(i), sc);
            checkOutput("fill no stall", sc, 32'd0);
        end
        expWr.push_back({16'h0034, 16'h3004});
        applyStimulus(1'b1, 1'b0, 16'h0034, 16'h3004);
        @(negedge clock);
        checkOutput("full stall 1", {31'd0, cpuStall}, 32'd1);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("full stall 2", {31'd0, cpuStall}, 32'd1);
        @(posedge clock);
        #1;
        memReady = 1'b1;
        @(negedge clock);
        checkOutput("full stall in pop cycle", {31'd0, cpuStall}, 32'd1);
        @(posedge clock);
        #1;
        memReady = 1'b0;
        @(negedge clock);
        checkOutput("stall released after pop", {31'd0, cpuStall}, 32'd0);
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("queue holds 4 writes", expWr.size(), 32'd4);
        memReady = 1'b1;
        waitDrain("drain full buffer");

        // Miss on empty buffer, zero-wait memory
        $display("[TB] miss 0x0040 empty buffer");
        memRdata = 16'hBEEF;
        doLoad(16'h0040, 16'hBEEF, 1'b1, sc);
        checkOutput("miss empty stall cycles", sc, 32'd2);

        // Miss with two queued writes: writes go out before the read
        $display("[TB] miss 0x0050 behind two stores");
        memReady = 1'b0;
        doStore(16'h0060, 16'h6001, sc);
        doStore(16'h0061, 16'h6002, sc);
        memRdata = 16'h1234;
        memReady = 1'b1;
        doLoad(16'h0050, 16'h1234, 1'b1, sc);
        checkOutput("miss behind writes stall cycles", sc, 32'd4);
        checkOutput("reads all observed", expRdAddr.size(), 32'd0);

        // Asynchronous reset mid-drain
        $display("[TB] reset mid-drain");
        memReady = 1'b0;
        doStore(16'h0070, 16'h7000, sc);
        doStore(16'h0071, 16'h7001, sc);
        doStore(16'h0072, 16'h7002, sc);
        @(negedge clock);
        checkOutput("pre-reset mem_write", {31'd0, memWrite}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async mem_write", {31'd0, memWrite}, 32'd0);
        checkOutput("async mem_read",  {31'd0, memRead},  32'd0);
        checkOutput("async mem_addr",  {16'h0, memAddr},  32'd0);
        checkOutput("async mem_wdata", {16'h0, memWdata}, 32'd0);
        checkOutput("async cpu_stall", {31'd0, cpuStall}, 32'd0);
        expWr.delete();
        memReady = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        snap = writeSeen;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("no writes after reset", writeSeen - snap, 32'd0);

        checkOutput("write queue empty", expWr.size(), 32'd0);
        checkOutput("load queue empty", expRd.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
